// File: rtl/tone_pkg.sv
// Shared types, note-period helpers and the song table for the tone sequencer.
// The table is read by note_rom; the top also uses the state enum.
package tone_pkg;

  localparam int unsigned TONE_CNT_W = 24;
  localparam int unsigned TONE_DUR_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_PLAY,
    ST_GAP
  } tone_state_e;

  typedef enum logic [3:0] {
    C4, D4, E4, F4, G4, A4, B4,
    C5, D5, E5, F5, G5, A5, B5
  } note_e;

  localparam logic [TONE_CNT_W-1:0] REST    = '0;
  localparam logic [TONE_DUR_W-1:0] END_DUR = '0;

  typedef struct packed {
    logic [TONE_CNT_W-1:0] period;
    logic [TONE_DUR_W-1:0] dur;
  } note_entry_t;

  function automatic int unsigned note_hz(input note_e n);
    case (n)
      C4: return 262;
      D4: return 294;
      E4: return 330;
      F4: return 349;
      G4: return 392;
      A4: return 440;
      B4: return 494;
      C5: return 523;
      D5: return 587;
      E5: return 659;
      F5: return 698;
      G5: return 784;
      A5: return 880;
      default: return 988;
    endcase
  endfunction

  // Half-period count for a square wave; clamped to 1 so a real note never reads as a rest.
  function automatic logic [TONE_CNT_W-1:0] note_period(input int unsigned clk_hz, input note_e n);
    int unsigned p;
    p = clk_hz / (2 * note_hz(n));
    if (p == 0) p = 1;
    return TONE_CNT_W'(p);
  endfunction

  function automatic note_entry_t mk_entry(input int unsigned period, input int unsigned dur);
    note_entry_t e;
    e.period = TONE_CNT_W'(period);
    e.dur    = TONE_DUR_W'(dur);
    return e;
  endfunction

  function automatic note_entry_t song_entry(input int unsigned clk_hz, input int unsigned song,
                                             input int unsigned idx);
    note_entry_t e;
    logic [3:0]  nsel;
    e.period = REST;
    e.dur    = END_DUR;
    nsel     = idx[3:0];
    case (song)
      0: begin
        if (idx == 0) e = mk_entry(1000, 3);
        else if (idx == 1) e = mk_entry(0, 2);
      end
      1: e = mk_entry((idx == 5) ? 0 : 200 + 37 * idx, 1 + idx % 3);
      2: begin
        if (idx < 14) begin
          e.period = note_period(clk_hz, note_e'(nsel));
          e.dur    = TONE_DUR_W'(1);
        end
      end
      default: begin
        if (idx == 0) e = mk_entry(500, 2);
        else if (idx == 1) e = mk_entry(700, 2);
      end
    endcase
    return e;
  endfunction

endpackage

// File: rtl/note_rom.sv
// Synchronous song table: address {song, note index} -> {period, dur}, one-cycle read latency.
module note_rom
  import tone_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int NUM_NOTES = 16,
  parameter int CNT_W     = 24,
  parameter int DUR_W     = 10
) (
  input  logic                             clk_i,
  input  logic [$clog2(NUM_NOTES)+1:0]     addr_i,
  output logic [CNT_W+DUR_W-1:0]           data_o
);

  localparam int DEPTH = 4 * NUM_NOTES;

  logic [CNT_W+DUR_W-1:0] rom [DEPTH];
  logic [CNT_W+DUR_W-1:0] data_q;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
    localparam note_entry_t E = song_entry(CLK_HZ, int'(gi / NUM_NOTES), int'(gi % NUM_NOTES));
    assign rom[gi] = {CNT_W'(E.period), DUR_W'(E.dur)};
  end

  always_ff @(posedge clk_i) begin
    data_q <= rom[addr_i];
  end

  assign data_o = data_q;

endmodule

// File: rtl/tone_sequencer.sv
// Melody controller: steps the song table and drives the divider MAXCOUNT and tone gate.
// Define TONE_SEQ_GAP_EN to insert a silent gap of GAP_TICKS ticks after every note.
module tone_sequencer
  import tone_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int TICK_HZ   = 1000,
  parameter int NUM_NOTES = 16,
  parameter int CNT_W     = 24,
  parameter int DUR_W     = 10,
  parameter int GAP_TICKS = 20
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic                         stop_i,
  input  logic                         loop_i,
  input  logic [1:0]                   song_sel_i,
  output logic [CNT_W-1:0]             maxcount_o,
  output logic                         tone_en_o,
  output logic                         busy_o,
  output logic [$clog2(NUM_NOTES)-1:0] note_idx_o,
  output logic                         done_o
);

  localparam int IDX_W    = $clog2(NUM_NOTES);
  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  tone_state_e            state_q;
  logic [1:0]             song_q;
  logic [IDX_W-1:0]       idx_q;
  logic [CNT_W-1:0]       maxcount_q;
  logic                   tone_en_q;
  logic                   busy_q;
  logic                   done_q;
  logic [PRE_W-1:0]       pre_q;
  logic [DUR_W-1:0]       tick_cnt_q;
  logic [DUR_W-1:0]       dur_q;

  logic [CNT_W+DUR_W-1:0] rom_data;
  logic [CNT_W-1:0]       rom_period;
  logic [DUR_W-1:0]       rom_dur;
  logic                   tick;
  logic                   span_done;
  logic                   last_idx;

  note_rom #(
    .CLK_HZ   (CLK_HZ),
    .NUM_NOTES(NUM_NOTES),
    .CNT_W    (CNT_W),
    .DUR_W    (DUR_W)
  ) u_note_rom (
    .clk_i (clk_i),
    .addr_i({song_q, idx_q}),
    .data_o(rom_data)
  );

  assign {rom_period, rom_dur} = rom_data;
  assign tick      = (pre_q == PRE_W'(TICK_DIV - 1));
  // dur_q holds the length of the current timed span (note, or gap when enabled).
  assign span_done = tick && (tick_cnt_q == dur_q - 1'b1);
  assign last_idx  = (idx_q == IDX_W'(NUM_NOTES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      song_q     <= '0;
      idx_q      <= '0;
      maxcount_q <= '0;
      tone_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pre_q      <= '0;
      tick_cnt_q <= '0;
      dur_q      <= '0;
    end else if (stop_i) begin
      state_q   <= ST_IDLE;
      tone_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == ST_PLAY || state_q == ST_GAP) begin
        if (tick) begin
          pre_q      <= '0;
          tick_cnt_q <= tick_cnt_q + 1'b1;
        end else begin
          pre_q <= pre_q + 1'b1;
        end
      end
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q <= ST_FETCH;
            song_q  <= song_sel_i;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_FETCH: state_q <= ST_LOAD;
        ST_LOAD: begin
          if (rom_dur == '0) begin
            if (loop_i) begin
              idx_q   <= '0;
              state_q <= ST_FETCH;
            end else begin
              state_q   <= ST_IDLE;
              busy_q    <= 1'b0;
              tone_en_q <= 1'b0;
              done_q    <= 1'b1;
            end
          end else begin
            state_q    <= ST_PLAY;
            maxcount_q <= rom_period;
            tone_en_q  <= (rom_period != '0);
            dur_q      <= rom_dur;
            pre_q      <= '0;
            tick_cnt_q <= '0;
          end
        end
        ST_PLAY: begin
          if (span_done) begin
            // Preload the gap span; the legato build moves straight to the next note.
            dur_q      <= DUR_W'(GAP_TICKS);
            pre_q      <= '0;
            tick_cnt_q <= '0;
`ifdef TONE_SEQ_GAP_EN
            state_q    <= ST_GAP;
            tone_en_q  <= 1'b0;
`else
            if (!last_idx) begin
              idx_q   <= idx_q + 1'b1;
              state_q <= ST_FETCH;
            end else if (loop_i) begin
              idx_q   <= '0;
              state_q <= ST_FETCH;
            end else begin
              state_q   <= ST_IDLE;
              busy_q    <= 1'b0;
              tone_en_q <= 1'b0;
              done_q    <= 1'b1;
            end
`endif
          end
        end
`ifdef TONE_SEQ_GAP_EN
        ST_GAP: begin
          if (span_done) begin
            if (!last_idx) begin
              idx_q   <= idx_q + 1'b1;
              state_q <= ST_FETCH;
            end else if (loop_i) begin
              idx_q   <= '0;
              state_q <= ST_FETCH;
            end else begin
              state_q   <= ST_IDLE;
              busy_q    <= 1'b0;
              tone_en_q <= 1'b0;
              done_q    <= 1'b1;
            end
          end
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign maxcount_o = maxcount_q;
  assign tone_en_o  = tone_en_q;
  assign busy_o     = busy_q;
  assign note_idx_o = idx_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Randomized bench for tone_sequencer (1 tick = 10 cycles) against a cycle-trace song model.
// Build with TONE_SEQ_GAP_EN defined to exercise the articulated-note variant.
module tb_tone_sequencer;

  localparam int TICK_CYC = 10;
  localparam int NN       = 16;
  localparam int GAP_T    = 20;
`ifdef TONE_SEQ_GAP_EN
  localparam int GAP_CYC  = GAP_T * TICK_CYC;
`else
  localparam int GAP_CYC  = 0;
`endif

  typedef struct packed {
    logic [23:0] mc;
    logic        te;
    logic        busy;
    logic        done;
    logic [3:0]  idx;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst, start, stop, loop_en;
  logic [1:0]  song_sel;
  logic [23:0] maxcount;
  logic        tone_en, busy, done;
  logic [3:0]  note_idx;

  int checks   = 0;
  int failures = 0;

  obs_t exp_q[$];
  logic [23:0] mc_m = '0;

  always #5 clk = ~clk;

  tone_sequencer #(
    .CLK_HZ   (1000),
    .TICK_HZ  (100),
    .NUM_NOTES(NN),
    .CNT_W    (24),
    .DUR_W    (10),
    .GAP_TICKS(GAP_T)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .stop_i    (stop),
    .loop_i    (loop_en),
    .song_sel_i(song_sel),
    .maxcount_o(maxcount),
    .tone_en_o (tone_en),
    .busy_o    (busy),
    .note_idx_o(note_idx),
    .done_o    (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d at t=%0t", tag, got, want, $time);
    end
  endtask

  task automatic chk_obs(input obs_t e);
    chk("maxcount", 32'(maxcount), 32'(e.mc));
    chk("tone_en",  32'(tone_en),  32'(e.te));
    chk("busy",     32'(busy),     32'(e.busy));
    chk("done",     32'(done),     32'(e.done));
    chk("note_idx", 32'(note_idx), 32'(e.idx));
  endtask

  function automatic void get_entry(input int song, input int idx, output int per, output int dur);
    per = 0;
    dur = 0;
    case (song)
      0: begin
        if (idx == 0) begin per = 1000; dur = 3; end
        else if (idx == 1) begin per = 0; dur = 2; end
      end
      1: begin
        per = (idx == 5) ? 0 : 200 + 37 * idx;
        dur = 1 + idx % 3;
      end
      3: begin
        if (idx == 0) begin per = 500; dur = 2; end
        else if (idx == 1) begin per = 700; dur = 2; end
      end
      default: ;
    endcase
  endfunction

  // Expected outputs for cycles 1..len after the START edge: two hold cycles per fetch,
  // dur*10 cycles per note, optional gap, then a done cycle and idle.
  task automatic build_expect(input int song, input bit lp, input int len);
    obs_t s;
    int   idx = 0;
    int   per, dur;
    bit   fin = 0;
    exp_q.delete();
    s.mc = mc_m; s.te = 1'b0; s.busy = 1'b1; s.done = 1'b0; s.idx = '0;
    while (exp_q.size() < len && !fin) begin
      s.busy = 1'b1; s.done = 1'b0; s.idx = 4'(idx);
      exp_q.push_back(s);
      exp_q.push_back(s);
      get_entry(song, idx, per, dur);
      if (dur == 0) begin
        if (lp) idx = 0;
        else fin = 1;
      end else begin
        s.mc = 24'(per);
        s.te = (per != 0);
        repeat (dur * TICK_CYC) exp_q.push_back(s);
        if (GAP_CYC > 0) begin
          s.te = 1'b0;
          repeat (GAP_CYC) exp_q.push_back(s);
        end
        if (idx == NN - 1) begin
          if (lp) idx = 0;
          else fin = 1;
        end else begin
          idx++;
        end
      end
    end
    if (fin) begin
      s.te = 1'b0; s.busy = 1'b0; s.done = 1'b1;
      exp_q.push_back(s);
      s.done = 1'b0;
      while (exp_q.size() < len) exp_q.push_back(s);
    end
  endtask

  // kind: 0 = play through, 1 = STOP after cycle abort_at, 2 = RST after cycle abort_at.
  task automatic run_song(input int song, input bit lp, input int len, input int kind, input int abort_at);
    obs_t e, last;
    int   aborted = 0;
    $display("run song=%0d loop=%0d len=%0d abort=%0d@%0d", song, lp, len, kind, abort_at);
    build_expect(song, lp, len);
    @(negedge clk);
    start = 1'b1; song_sel = 2'(song); loop_en = lp; stop = 1'b0; rst = 1'b0;
    last = '0;
    for (int c = 1; c <= len; c++) begin
      @(posedge clk);
      #1;
      if (aborted == 1) e = '{mc: last.mc, te: 1'b0, busy: 1'b0, done: 1'b0, idx: last.idx};
      else if (aborted == 2) e = '0;
      else e = exp_q[c-1];
      chk_obs(e);
      last = e;
      if (c < len) begin
        @(negedge clk);
        start    = e.busy ? 1'($urandom_range(0, 1)) : 1'b0;
        song_sel = 2'($urandom_range(0, 3));
        stop     = (kind == 1 && c == abort_at);
        rst      = (kind == 2 && c == abort_at);
        if (stop) aborted = 1;
        if (rst)  aborted = 2;
      end
    end
    @(negedge clk);
    start = 1'b0; stop = 1'b1; rst = 1'b0;
    @(posedge clk);
    #1;
    e = '{mc: last.mc, te: 1'b0, busy: 1'b0, done: 1'b0, idx: last.idx};
    chk_obs(e);
    mc_m = e.mc;
    @(negedge clk);
    stop = 1'b0;
  endtask

  initial begin
    obs_t e;
    int   song, len, kind, at;
    bit   lp;
    rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; song_sel = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_obs('0);
    @(negedge clk);
    rst = 1'b0;

    // Basic song, looping song, STOP mid-note.
    run_song(0, 1'b0, 80 + 2 * GAP_CYC, 0, 0);
    run_song(0, 1'b1, 160 + 4 * GAP_CYC, 0, 0);
    run_song(0, 1'b0, 60, 1, 15);

    // START and STOP together while idle stays idle.
    @(negedge clk);
    start = 1'b1; stop = 1'b1; song_sel = 2'd0;
    @(posedge clk);
    #1;
    e = '{mc: mc_m, te: 1'b0, busy: 1'b0, done: 1'b0, idx: note_idx};
    chk("start_stop_busy", 32'(busy), 32'(0));
    chk("start_stop_mc", 32'(maxcount), 32'(mc_m));
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    @(posedge clk);
    #1;
    chk("start_stop_idle", 32'(busy), 32'(0));

    // Full 16-note song, reset mid-note, two-note song (gap check in gap build).
    run_song(1, 1'b0, 400 + NN * GAP_CYC, 0, 0);
    run_song(1, 1'b0, 200, 2, 60);
    run_song(3, 1'b0, 60 + 2 * GAP_CYC, 0, 0);

    for (int r = 0; r < 10; r++) begin
      case ($urandom_range(0, 2))
        0: song = 0;
        1: song = 1;
        default: song = 3;
      endcase
      lp   = 1'($urandom_range(0, 1));
      len  = $urandom_range(60, 420) + 2 * GAP_CYC;
      kind = $urandom_range(0, 2);
      at   = $urandom_range(1, len - 1);
      run_song(song, lp, len, kind, at);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
